// File: rtl/alu_bist_ft_n.sv
// Fault-tolerant ALU: one primary plus NUM_SPARES spare cores, with a BIST sequencer that
// sweeps each core with fixed vectors and keeps sticky per-core fault flags.
module alu_bist_ft_n #(
  parameter int WIDTH       = 32,
  parameter int NUM_SPARES  = 2,
  parameter int TEST_PERIOD = 1024,
  localparam int NU         = NUM_SPARES + 1,
  localparam int UW         = (NU > 1) ? $clog2(NU) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             OverFlow,
  output logic             Zero,
  output logic             Negative,
  input  logic             test_start,
  input  logic [NU-1:0]    force_fault,
  input  logic [NU-1:0]    inject_err,
  output logic             test_busy,
  output logic             test_done,
  output logic [NU-1:0]    fault_status,
  output logic [UW-1:0]    active_unit,
  output logic             all_failed,
  output logic [1:0]       state_o
);

  localparam int TW = (TEST_PERIOD > 1) ? $clog2(TEST_PERIOD) : 1;
  localparam logic [TW-1:0] TMAX = TW'((TEST_PERIOD > 0) ? TEST_PERIOD - 1 : 0);
  localparam logic [UW-1:0] LAST = UW'(NU - 1);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SLT = 3'b101;

  function automatic logic [WIDTH-1:0] pat_f();
    logic [WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [WIDTH-1:0] PAT  = pat_f();
  localparam logic [WIDTH-1:0] ONES = '1;

  // Returns {carry, overflow, result}; SLT reuses the subtractor's sign/overflow.
  function automatic logic [WIDTH+1:0] alu_f(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] r;
    logic             sub, v, c, ov;
    sub = (op == OP_SUB) || (op == OP_SLT);
    bb  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    v   = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    r   = '0;
    c   = 1'b0;
    ov  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin r = sum[WIDTH-1:0]; c = sum[WIDTH]; ov = v; end
      OP_AND:         r = a & b;
      OP_OR:          r = a | b;
      OP_XOR:         r = a ^ b;
      OP_SLT:         r = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ v};
      default:        r = '0;
    endcase
    return {c, ov, r};
  endfunction

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [UW-1:0]    tgt_q, tgt_d;
  logic [2:0]       vec_q, vec_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [NU-1:0]    fault_q, fault_d;

  logic [NU-1:0]    healthy;
  logic [UW-1:0]    act_idx, alt_idx, serve;
  logic             any_h, alt_ok, testing, mismatch, auto_fire;
  logic [2:0]       tv_op;
  logic [WIDTH-1:0] tv_a, tv_b, tv_exp;
  logic [WIDTH-1:0] core_res [NU];
  logic [NU-1:0]    core_c, core_v;

  assign healthy   = ~fault_q & ~force_fault;
  assign auto_fire = (TEST_PERIOD != 0) && (timer_q == TMAX);

  // Lowest-index healthy core, and lowest-index healthy core other than the test target.
  always_comb begin
    act_idx = '0;
    any_h   = 1'b0;
    alt_idx = '0;
    alt_ok  = 1'b0;
    for (int i = NU - 1; i >= 0; i--) begin
      if (healthy[i]) begin
        act_idx = UW'(i);
        any_h   = 1'b1;
      end
      if (healthy[i] && (tgt_q != UW'(i))) begin
        alt_idx = UW'(i);
        alt_ok  = 1'b1;
      end
    end
    serve   = act_idx;
    testing = 1'b0;
    if (state_q == S_RUN) begin
      if (tgt_q != act_idx) begin
        testing = 1'b1;
      end else if (alt_ok) begin
        serve   = alt_idx;
        testing = 1'b1;
      end else begin
        serve = tgt_q;
      end
    end
  end

  always_comb begin
    tv_op  = OP_ADD;
    tv_a   = '0;
    tv_b   = ONES;
    tv_exp = ONES;
    case (vec_q)
      3'd0, 3'd1: begin tv_op = OP_ADD; tv_a = '0;    tv_b = ONES; tv_exp = ONES; end
      3'd2, 3'd3: begin tv_op = OP_XOR; tv_a = ~PAT;  tv_b = PAT;  tv_exp = ONES; end
      3'd4:       begin tv_op = OP_AND; tv_a = PAT;   tv_b = ~PAT; tv_exp = '0;   end
      3'd5:       begin tv_op = OP_OR;  tv_a = PAT;   tv_b = ~PAT; tv_exp = ONES; end
      3'd6:       begin tv_op = OP_SUB; tv_a = PAT;   tv_b = ~PAT;
                        tv_exp = ~PAT + {{(WIDTH-1){1'b0}}, 1'b1}; end
      default:    begin tv_op = OP_SLT; tv_a = WIDTH'(1); tv_b = WIDTH'(2);
                        tv_exp = WIDTH'(1); end
    endcase
  end

  // Only the core under test sees the vectors; everyone else follows the datapath.
  always_comb begin
    for (int i = 0; i < NU; i++) begin
      logic [WIDTH+1:0] o;
      if (testing && (tgt_q == UW'(i))) o = alu_f(tv_op, tv_a, tv_b);
      else                              o = alu_f(ALUControl, A, B);
      core_res[i] = o[WIDTH-1:0] ^ {{(WIDTH-1){1'b0}}, inject_err[i]};
      core_c[i]   = o[WIDTH+1];
      core_v[i]   = o[WIDTH];
    end
  end

  assign mismatch = (core_res[tgt_q] != tv_exp) ||
                    ((core_res[tgt_q] == '0) != (tv_exp == '0));

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    vec_d   = vec_q;
    timer_d = timer_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (test_start || auto_fire) begin
          state_d = S_RUN;
          timer_d = '0;
          tgt_d   = '0;
          vec_d   = '0;
        end else if (TEST_PERIOD != 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RUN: begin
        if (testing && mismatch) fault_d[tgt_q] = 1'b1;
        vec_d = vec_q + 3'd1;
        if (vec_q == 3'd7) begin
          if (tgt_q == LAST) begin
            state_d = S_DONE;
            tgt_d   = '0;
          end else begin
            tgt_d = tgt_q + UW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      vec_q   <= '0;
      timer_q <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      vec_q   <= vec_d;
      timer_q <= timer_d;
      fault_q <= fault_d;
    end
  end

  assign Result       = core_res[serve];
  assign Carry        = core_c[serve];
  assign OverFlow     = core_v[serve];
  assign Zero         = (Result == '0);
  assign Negative     = Result[WIDTH-1];
  assign test_busy    = (state_q == S_RUN);
  assign test_done    = (state_q == S_DONE);
  assign fault_status = fault_q;
  assign active_unit  = serve;
  assign all_failed   = !any_h;
  assign state_o      = state_q;

endmodule

// File: tb/tb_alu_bist_ft_n.sv
// Directed bench for alu_bist_ft_n: vector table for the datapath, hand-written
// sequences for self-test runs, fault injection, forced faults, reset and auto-test.
module tb_alu_bist_ft_n;
  localparam int W  = 32;
  localparam int NU = 3;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010,
                         OR_ = 3'b011, XOR_ = 3'b100, SLT = 3'b101;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
    logic         cv;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a, b;
  logic [2:0]    op;
  logic          ts, ts2;
  logic [NU-1:0] ff, inj;
  logic [NU-1:0] zero_nu = '0;

  logic [W-1:0]  result, result_a;
  logic          carry, ovf, zero, neg, carry_a, ovf_a, zero_a, neg_a;
  logic          busy, done, all_failed, busy_a, done_a, all_failed_a;
  logic [NU-1:0] fault, fault_a;
  logic [1:0]    active, active_a, state, state_a;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;
  vec_t          tbl[12];
  int            len, k, g;

  always #5 clk = ~clk;

  alu_bist_ft_n #(.WIDTH(W), .NUM_SPARES(2), .TEST_PERIOD(0)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .ALUControl(op),
    .Result(result), .Carry(carry), .OverFlow(ovf), .Zero(zero), .Negative(neg),
    .test_start(ts), .force_fault(ff), .inject_err(inj),
    .test_busy(busy), .test_done(done), .fault_status(fault),
    .active_unit(active), .all_failed(all_failed), .state_o(state)
  );

  alu_bist_ft_n #(.WIDTH(W), .NUM_SPARES(2), .TEST_PERIOD(16)) dut_auto (
    .clk(clk), .rst(rst), .A(a), .B(b), .ALUControl(op),
    .Result(result_a), .Carry(carry_a), .OverFlow(ovf_a), .Zero(zero_a), .Negative(neg_a),
    .test_start(ts2), .force_fault(zero_nu), .inject_err(zero_nu),
    .test_busy(busy_a), .test_done(done_a), .fault_status(fault_a),
    .active_unit(active_a), .all_failed(all_failed_a), .state_o(state_a)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ts = 1'b0; ts2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulses test_start, measures test_busy length, optionally streams ADD/XOR and
  // checks the datapath and serving core every cycle of the run.
  task automatic do_run(input string tag, input bit chk_dp, output int run_len);
    int guard;
    @(negedge clk); ts = 1'b1;
    @(negedge clk); ts = 1'b0;
    run_len = 0;
    guard   = 0;
    while (busy && guard < 200) begin
      run_len++;
      guard++;
      a  = $urandom;
      b  = $urandom;
      op = (run_len % 2 == 1) ? ADD : XOR_;
      #1;
      if (chk_dp) begin
        exp_q.push_back((op == ADD) ? a + b : a ^ b);
        chk($sformatf("%s dp_res c%0d", tag, run_len), result, exp_q.pop_front());
        chk($sformatf("%s serve c%0d", tag, run_len), active,
            ((run_len - 1) / 8 == 0) ? 2'd1 : 2'd0);
      end
      @(negedge clk);
    end
    chk({tag, " run_len"}, run_len, 24);
    chk({tag, " done_pulse"}, done, 1);
    @(negedge clk);
    chk({tag, " done_low"}, done, 0);
    chk({tag, " busy_low"}, busy, 0);
  endtask

  initial begin
    tbl[0]  = '{ADD,  32'd7,          32'd5,          32'd12,         0, 0, 0, 0, 1};
    tbl[1]  = '{SUB,  32'd5,          32'd5,          32'd0,          1, 0, 1, 0, 1};
    tbl[2]  = '{ADD,  32'hFFFF_FFFF,  32'd1,          32'd0,          1, 0, 1, 0, 1};
    tbl[3]  = '{ADD,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  0, 1, 0, 1, 1};
    tbl[4]  = '{SUB,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1, 1, 0, 0, 1};
    tbl[5]  = '{AND_, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  0, 0, 0, 1, 0};
    tbl[6]  = '{OR_,  32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0,  0, 0, 0, 0, 0};
    tbl[7]  = '{XOR_, 32'hFFFF_0000,  32'hFFFF_FFFF,  32'h0000_FFFF,  0, 0, 0, 0, 0};
    tbl[8]  = '{SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          0, 0, 0, 0, 0};
    tbl[9]  = '{SLT,  32'd5,          32'd3,          32'd0,          0, 0, 1, 0, 0};
    tbl[10] = '{SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  0, 0, 0, 1, 1};
    tbl[11] = '{XOR_, 32'h1234_5678,  32'h1234_5678,  32'd0,          0, 0, 1, 0, 0};

    rst = 1'b1; ts = 1'b0; ts2 = 1'b0; ff = '0; inj = '0;
    a = '0; b = '0; op = ADD;
    do_reset();

    // Reset state
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst fault", fault, 0);
    chk("rst active", active, 0);
    chk("rst all_failed", all_failed, 0);
    chk("rst state", state, 0);

    // Datapath vector table, both instances
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a = tbl[i].a; b = tbl[i].b; op = tbl[i].op;
      #1;
      chk($sformatf("tbl%0d res", i), result, tbl[i].res);
      chk($sformatf("tbl%0d zero", i), zero, tbl[i].z);
      chk($sformatf("tbl%0d neg", i), neg, tbl[i].n);
      chk($sformatf("tbl%0d res_auto", i), result_a, tbl[i].res);
      chk($sformatf("tbl%0d zero_auto", i), zero_a, tbl[i].z);
      chk($sformatf("tbl%0d neg_auto", i), neg_a, tbl[i].n);
      if (tbl[i].cv) begin
        chk($sformatf("tbl%0d carry", i), carry, tbl[i].c);
        chk($sformatf("tbl%0d ovf", i), ovf, tbl[i].v);
        chk($sformatf("tbl%0d carry_auto", i), carry_a, tbl[i].c);
        chk($sformatf("tbl%0d ovf_auto", i), ovf_a, tbl[i].v);
      end
    end

    // Clean run: 24 busy cycles, uninterrupted datapath, no flags
    do_run("clean", 1'b1, len);
    chk("clean fault", fault, 0);
    chk("clean active", active, 0);

    // Injected error on core 0
    inj = 3'b001;
    @(negedge clk); ts = 1'b1;
    @(negedge clk); ts = 1'b0;
    a = 32'd3; b = 32'd4; op = ADD;
    #1;
    chk("inj0 fault_pre", fault, 3'b000);
    chk("inj0 active_pre", active, 1);
    chk("inj0 res_pre", result, 32'd7);
    chk("inj0 state_run", state, 1);
    @(negedge clk);
    chk("inj0 fault_set", fault, 3'b001);
    chk("inj0 active", active, 1);
    chk("inj0 res", result, 32'd7);
    g = 0;
    while (!done && g < 100) begin
      g++;
      @(negedge clk);
    end
    chk("inj0 done_seen", done, 1);
    chk("inj0 fault_end", fault, 3'b001);
    chk("inj0 active_end", active, 1);
    chk("inj0 res_end", result, 32'd7);
    inj = '0;
    do_reset();
    chk("rst2 fault", fault, 0);

    // All cores injected: last healthy core cannot be tested without a server
    inj = 3'b111;
    do_run("all1", 1'b0, len);
    chk("all1 fault", fault, 3'b011);
    chk("all1 active", active, 2);
    chk("all1 all_failed", all_failed, 0);
    do_run("all2", 1'b0, len);
    chk("all2 fault", fault, 3'b011);
    ff = 3'b100;
    #1;
    chk("force all_failed", all_failed, 1);
    chk("force active", active, 0);
    do_run("all3", 1'b0, len);
    chk("all3 fault", fault, 3'b111);
    ff = '0;
    #1;
    chk("all3 all_failed", all_failed, 1);
    chk("all3 active", active, 0);

    // Reset in the middle of a run
    @(negedge clk); ts = 1'b1;
    @(negedge clk); ts = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    inj = '0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst fault", fault, 0);
    chk("midrst all_failed", all_failed, 0);
    chk("midrst active", active, 0);

    // Auto-test after 16 idle edges; test_start mid-run is ignored
    do_reset();
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (busy_a) break;
    end
    chk("auto rise_edge", k, 16);
    len = 1;
    g   = 0;
    @(negedge clk);
    while (busy_a && g < 200) begin
      len++;
      g++;
      ts2 = (len == 6);
      @(negedge clk);
    end
    ts2 = 1'b0;
    chk("auto run_len", len, 24);
    chk("auto done", done_a, 1);
    chk("auto state_done", state_a, 2);
    @(negedge clk);
    chk("auto done_low", done_a, 0);
    chk("auto no_requeue", busy_a, 0);
    chk("auto fault", fault_a, 0);
    chk("auto active", active_a, 0);
    chk("auto all_failed", all_failed_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
